fpadd_seq_ctrl: RTL

Parametrised sequencer and display controller for the FP adder system. Walks an operand memory of NUM entries, one entry per user step. Each step issues one addition to an external multi-cycle FP adder through a start/done handshake and captures the result. The result is shown on a DIGITS-wide multiplexed seven-segment display and on an 8-bit LED bank. It generalises the fixed two-digit, fixed-NUM system: width, depth, digit count, refresh rate, wrap mode and adder timeout are all parameters.

---
 rtl/fpadd_seq_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/fpadd_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fpadd_seq_ctrl
// Brief   : Steps through an operand memory one entry per button press,
//           issues each pair to a multi-cycle FP adder via start/done and
//           shows the result on a scanned seven-segment display and LEDs.
// Revision: 1.0 - initial release
// ============================================================================
module fpadd_seq_ctrl #(
   parameter int WIDTH   = 32,
   parameter int NUM     = 10,
   parameter int ADDR_W  = 4,
   parameter int DIGITS  = 2,
   parameter int REFRESH = 1000,
   parameter int WRAP    = 0,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_en,
   output logic [ADDR_W-1:0]  o_mem_addr,
   input  logic [2*WIDTH-1:0] i_mem_rdata,
   output logic [WIDTH-1:0]   o_add_a,
   output logic [WIDTH-1:0]   o_add_b,
   output logic               o_add_start,
   input  logic               i_add_done,
   input  logic [WIDTH-1:0]   i_add_result,
   output logic [7:0]         o_leds,
   output logic [DIGITS-1:0]  o_seg_an,
   output logic [6:0]         o_seg,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err
);

   localparam int c_TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int c_REF_W  = (REFRESH > 1) ? $clog2(REFRESH) : 1;
   localparam int c_DIG_W  = (DIGITS > 1)  ? $clog2(DIGITS)  : 1;

   localparam logic [ADDR_W-1:0]   c_LAST  = ADDR_W'(NUM - 1);
   localparam logic [c_TCNT_W-1:0] c_TLAST = c_TCNT_W'(TIMEOUT - 1);
   localparam logic [c_REF_W-1:0]  c_RLAST = c_REF_W'(REFRESH - 1);
   localparam logic [c_DIG_W-1:0]  c_DLAST = c_DIG_W'(DIGITS - 1);
   localparam bit                  c_WRAP  = (WRAP != 0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_SHOW  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   state_t              r_state;
   logic                r_en_meta;
   logic                r_en_sync;
   logic                r_en_prev;
   logic                w_step;
   logic [ADDR_W-1:0]   r_index;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [WIDTH-1:0]    r_add_a;
   logic [WIDTH-1:0]    r_add_b;
   logic                r_add_start;
   logic [c_TCNT_W-1:0] r_tcnt;
   logic [WIDTH-1:0]    r_result;
   logic                r_valid;
   logic                r_busy;
   logic                r_done;
   logic                r_err;
   logic [c_REF_W-1:0]  r_ref;
   logic [c_DIG_W-1:0]  r_digit;
   logic [3:0]          w_nib;
   logic [6:0]          w_glyph;
   logic                w_unused_result;

   // Bring the button into the clock domain and remember its previous level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en_meta <= 1'b0;
         r_en_sync <= 1'b0;
         r_en_prev <= 1'b0;
      end else begin
         r_en_meta <= i_en;
         r_en_sync <= r_en_meta;
         r_en_prev <= r_en_sync;
      end
   end

   // One step per low-to-high transition, regardless of how long it is held
   assign w_step = r_en_sync & ~r_en_prev;

   // Sequencer: fetch, issue, wait for the adder (or give up), then display
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_index     <= '0;
         r_mem_addr  <= '0;
         r_add_a     <= '0;
         r_add_b     <= '0;
         r_add_start <= 1'b0;
         r_tcnt      <= '0;
         r_result    <= '0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_add_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_step) begin
                  r_mem_addr <= r_index;
                  r_busy     <= 1'b1;
                  r_state    <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               // The start pulse lines up with the read data arriving in ISSUE
               r_add_start <= 1'b1;
               r_state     <= ST_ISSUE;
            end
            ST_ISSUE: begin
               r_add_a <= i_mem_rdata[2*WIDTH-1:WIDTH];
               r_add_b <= i_mem_rdata[WIDTH-1:0];
               r_tcnt  <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (i_add_done) begin
                  r_result <= i_add_result;
                  r_valid  <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= ST_SHOW;
               end else if (r_tcnt == c_TLAST) begin
                  // Adder never answered: show zero and latch the error
                  r_result <= '0;
                  r_valid  <= 1'b1;
                  r_err    <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= ST_SHOW;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
               end
            end
            ST_SHOW: begin
               if (w_step) begin
                  if (r_index != c_LAST) begin
                     r_index    <= r_index + 1'b1;
                     r_mem_addr <= r_index + 1'b1;
                     r_busy     <= 1'b1;
                     r_state    <= ST_FETCH;
                  end else if (c_WRAP) begin
                     r_index    <= '0;
                     r_mem_addr <= '0;
                     r_busy     <= 1'b1;
                     r_state    <= ST_FETCH;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_DONE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Refresh timer; each terminal count advances the scanned digit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ref   <= '0;
         r_digit <= '0;
      end else if (r_ref == c_RLAST) begin
         r_ref   <= '0;
         r_digit <= (r_digit == c_DLAST) ? '0 : r_digit + 1'b1;
      end else begin
         r_ref <= r_ref + 1'b1;
      end
   end

   // One-hot anode select and nibble pick for the digit being scanned
   always_comb begin
      o_seg_an = '0;
      w_nib    = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (r_digit == c_DIG_W'(k)) begin
            o_seg_an[k] = 1'b1;
            w_nib       = r_result[WIDTH-1-4*k -: 4];
         end
      end
   end

   // Hex glyph decode, segments ordered {a,b,c,d,e,f,g}
   always_comb begin
      w_glyph = 7'b0000000;
      case (w_nib)
         4'h0: w_glyph = 7'b1111110;
         4'h1: w_glyph = 7'b0110000;
         4'h2: w_glyph = 7'b1101101;
         4'h3: w_glyph = 7'b1111001;
         4'h4: w_glyph = 7'b0110011;
         4'h5: w_glyph = 7'b1011011;
         4'h6: w_glyph = 7'b1011111;
         4'h7: w_glyph = 7'b1110000;
         4'h8: w_glyph = 7'b1111111;
         4'h9: w_glyph = 7'b1111011;
         4'hA: w_glyph = 7'b1110111;
         4'hB: w_glyph = 7'b0011111;
         4'hC: w_glyph = 7'b1001110;
         4'hD: w_glyph = 7'b0111101;
         4'hE: w_glyph = 7'b1001111;
         4'hF: w_glyph = 7'b1000111;
         default: w_glyph = 7'b0000000;
      endcase
   end

   // Operands are presented straight from the memory while the start pulse
   // is high, and held from the latched copy afterwards
   assign o_add_a     = (r_state == ST_ISSUE) ? i_mem_rdata[2*WIDTH-1:WIDTH] : r_add_a;
   assign o_add_b     = (r_state == ST_ISSUE) ? i_mem_rdata[WIDTH-1:0]       : r_add_b;
   assign o_add_start = r_add_start;
   assign o_mem_addr  = r_mem_addr;
   assign o_leds      = r_result[WIDTH-1 -: 8];
   assign o_seg       = r_valid ? w_glyph : 7'b0000000;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;

   // Nibbles beyond the displayed digits are kept but never shown
   assign w_unused_result = ^r_result;

endmodule
`default_nettype wire
